// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - UART receive FIFO / holding register with LSR status and interrupts
//
// Purpose:
//   Stores received characters with their status bits {bi,fe,pe,data}.
//   There are 16 entries in FIFO mode and 1 entry in holding-register mode.
//   The block presents the head entry to the bus. It derives the LSR
//   receive bits, a trigger-level interrupt and an optional
//   character-timeout interrupt.
//
// Build option:
//   UART_RX_TIMEOUT_EN - when defined, char_tick drives a 4-character
//   timeout interrupt. When undefined, rx_timeout_int is tied 0.
//
// Ports:
//   pclk, presetn          clock, asynchronous active-low reset
//   utrrst                 synchronous receiver flush
//   fifo_en                1 = 16-deep FIFO, 0 = 1-deep holding register
//   rx_trig                trigger level select (1/4/8/14)
//   receive_load_en        push strobe for rsr_data and its status bits
//   rsr_data               received character
//   parity_error           status of the received character
//   frame_error            status of the received character
//   uart_break             status of the received character
//   rbr_rd                 pop strobe
//   lsr_rd                 LSR read strobe, clears overrun_error
//   char_tick              one pulse per character time
//   rbr_data               head character
//   lsr_pe, lsr_fe, lsr_bi head status bits
//   data_ready             LSR receive bit
//   overrun_error          LSR receive bit
//   rx_fifo_error          LSR receive bit
//   rx_count               number of stored entries (0..16)
//   rx_trig_int            interrupt request
//   rx_timeout_int         interrupt request
module uart_rx_fifo_ctrl (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       utrrst,
  input  logic       fifo_en,
  input  logic [1:0] rx_trig,
  input  logic       receive_load_en,
  input  logic [7:0] rsr_data,
  input  logic       parity_error,
  input  logic       frame_error,
  input  logic       uart_break,
  input  logic       rbr_rd,
  input  logic       lsr_rd,
  input  logic       char_tick,
  output logic [7:0] rbr_data,
  output logic       data_ready,
  output logic       overrun_error,
  output logic       lsr_pe,
  output logic       lsr_fe,
  output logic       lsr_bi,
  output logic       rx_fifo_error,
  output logic [4:0] rx_count,
  output logic       rx_trig_int,
  output logic       rx_timeout_int
);

  logic [10:0] mem [16];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic [4:0]  err_cnt;
  logic        prev_fifo_en;

  logic        flush;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        ovr_set;
  logic        err_inc;
  logic        err_dec;
  logic [4:0]  capacity;
  logic [4:0]  trig_level;
  logic [10:0] head;

  // A mode change invalidates whatever was stored under the old capacity.
  assign flush    = utrrst | (fifo_en ^ prev_fifo_en);
  assign capacity = fifo_en ? 5'd16 : 5'd1;
  assign empty    = (rx_count == 5'd0);
  assign full     = (rx_count == capacity);

  // When full, a push is accepted only if a pop frees the head slot in the same cycle.
  assign pop      = rbr_rd & ~empty & ~flush;
  assign push     = receive_load_en & (~full | rbr_rd) & ~flush;
  assign ovr_set  = receive_load_en & full & ~rbr_rd & ~flush;

  assign head     = mem[rd_ptr];
  assign err_inc  = push & (parity_error | frame_error | uart_break);
  assign err_dec  = pop & (|head[10:8]);

  always_ff @(posedge pclk) begin
    if (push) begin
      mem[wr_ptr] <= {uart_break, frame_error, parity_error, rsr_data};
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr       <= 4'd0;
      rd_ptr       <= 4'd0;
      rx_count     <= 5'd0;
      err_cnt      <= 5'd0;
      prev_fifo_en <= 1'b0;
    end else begin
      prev_fifo_en <= fifo_en;
      if (flush) begin
        wr_ptr   <= 4'd0;
        rd_ptr   <= 4'd0;
        rx_count <= 5'd0;
        err_cnt  <= 5'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 4'd1;
        if (pop)  rd_ptr <= rd_ptr + 4'd1;
        rx_count <= rx_count + {4'd0, push} - {4'd0, pop};
        err_cnt  <= err_cnt + {4'd0, err_inc} - {4'd0, err_dec};
      end
    end
  end

  // A new overrun in the same cycle as an LSR read wins, so the event is never lost.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      overrun_error <= 1'b0;
    end else if (utrrst) begin
      overrun_error <= 1'b0;
    end else if (ovr_set) begin
      overrun_error <= 1'b1;
    end else if (lsr_rd) begin
      overrun_error <= 1'b0;
    end
  end

  always_comb begin
    trig_level = 5'd1;
    case (rx_trig)
      2'b00:   trig_level = 5'd1;
      2'b01:   trig_level = 5'd4;
      2'b10:   trig_level = 5'd8;
      default: trig_level = 5'd14;
    endcase
  end

  assign rbr_data      = empty ? 8'd0 : head[7:0];
  assign lsr_pe        = ~empty & head[8];
  assign lsr_fe        = ~empty & head[9];
  assign lsr_bi        = ~empty & head[10];
  assign data_ready    = ~empty;
  assign rx_fifo_error = (err_cnt != 5'd0) & fifo_en;
  assign rx_trig_int   = fifo_en ? (rx_count >= trig_level) : data_ready;

`ifdef UART_RX_TIMEOUT_EN
  logic [1:0] to_cnt;

  // The counter sits at 3 after three idle character times; the fourth tick raises the request.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      to_cnt         <= 2'd0;
      rx_timeout_int <= 1'b0;
    end else if (flush) begin
      to_cnt         <= 2'd0;
      rx_timeout_int <= 1'b0;
    end else begin
      if (push || rbr_rd || empty) begin
        to_cnt <= 2'd0;
      end else if (char_tick && fifo_en) begin
        to_cnt <= to_cnt + 2'd1;
      end
      if (push || rbr_rd) begin
        rx_timeout_int <= 1'b0;
      end else if (char_tick && fifo_en && !empty && to_cnt == 2'd3) begin
        rx_timeout_int <= 1'b1;
      end
    end
  end
`else
  logic unused_char_tick;
  assign unused_char_tick = char_tick;
  assign rx_timeout_int   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb/tb_uart_rx_fifo_ctrl.sv - self-checking bench for uart_rx_fifo_ctrl
module tb_uart_rx_fifo_ctrl;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       utrrst = 1'b0;
  logic       fifo_en = 1'b0;
  logic [1:0] rx_trig = 2'b00;
  logic       receive_load_en = 1'b0;
  logic [7:0] rsr_data = 8'd0;
  logic       parity_error = 1'b0;
  logic       frame_error = 1'b0;
  logic       uart_break = 1'b0;
  logic       rbr_rd = 1'b0;
  logic       lsr_rd = 1'b0;
  logic       char_tick = 1'b0;
  logic [7:0] rbr_data;
  logic       data_ready, overrun_error, lsr_pe, lsr_fe, lsr_bi, rx_fifo_error;
  logic [4:0] rx_count;
  logic       rx_trig_int, rx_timeout_int;

  int errors = 0;
  int checks = 0;
  logic [10:0] sb[$];

  uart_rx_fifo_ctrl dut (
    .pclk(pclk), .presetn(presetn), .utrrst(utrrst), .fifo_en(fifo_en),
    .rx_trig(rx_trig), .receive_load_en(receive_load_en), .rsr_data(rsr_data),
    .parity_error(parity_error), .frame_error(frame_error), .uart_break(uart_break),
    .rbr_rd(rbr_rd), .lsr_rd(lsr_rd), .char_tick(char_tick),
    .rbr_data(rbr_data), .data_ready(data_ready), .overrun_error(overrun_error),
    .lsr_pe(lsr_pe), .lsr_fe(lsr_fe), .lsr_bi(lsr_bi), .rx_fifo_error(rx_fifo_error),
    .rx_count(rx_count), .rx_trig_int(rx_trig_int), .rx_timeout_int(rx_timeout_int)
  );

  always #5 pclk = ~pclk;

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  // Drives one load (optionally with a same-cycle pop) and updates the scoreboard.
  task automatic load(input logic [7:0] d, input logic pe, input logic fe,
                      input logic bi, input logic rd);
    int cap;
    cap = fifo_en ? 16 : 1;
    if (sb.size() < cap || rd) begin
      if (rd && sb.size() != 0) void'(sb.pop_front());
      sb.push_back({bi, fe, pe, d});
    end
    rsr_data = d; parity_error = pe; frame_error = fe; uart_break = bi;
    receive_load_en = 1'b1; rbr_rd = rd;
    cyc();
    receive_load_en = 1'b0; rbr_rd = 1'b0;
    parity_error = 1'b0; frame_error = 1'b0; uart_break = 1'b0;
  endtask

  task automatic read();
    if (sb.size() != 0) void'(sb.pop_front());
    rbr_rd = 1'b1;
    cyc();
    rbr_rd = 1'b0;
  endtask

  task automatic set_fifo_en(input logic v);
    fifo_en = v;
    cyc();
    sb.delete();
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    cyc(); cyc();
    checks++;
    if ({rbr_data, data_ready, overrun_error, lsr_pe, lsr_fe, lsr_bi, rx_fifo_error,
         rx_count, rx_trig_int, rx_timeout_int} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rx_count=%0d rbr_data=%h dr=%b ovr=%b want all 0",
               rx_count, rbr_data, data_ready, overrun_error);
    end
    presetn = 1'b1;
    cyc();
    checks++;
    if (rx_count !== 5'd0 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rx_count=%0d dr=%b want 0 0", rx_count, data_ready);
    end
  endtask

  task automatic test_basic();
    set_fifo_en(1'b1);
    load(8'h41, 0, 0, 0, 0); load(8'h42, 0, 0, 0, 0); load(8'h43, 0, 0, 0, 0);
    checks++;
    if (rx_count !== 5'd3 || rbr_data !== 8'h41) begin
      errors++;
      $display("FAIL basic_load: got count=%0d data=%h want 3 41", rx_count, rbr_data);
    end
    read();
    checks++;
    if (rx_count !== 5'd2 || rbr_data !== 8'h42) begin
      errors++;
      $display("FAIL basic_pop: got count=%0d data=%h want 2 42", rx_count, rbr_data);
    end
    while (sb.size() != 0) begin
      checks++;
      if (rbr_data !== sb[0][7:0]) begin
        errors++;
        $display("FAIL basic_drain: got %h want %h", rbr_data, sb[0][7:0]);
      end
      read();
    end
    checks++;
    if (rx_count !== 5'd0 || data_ready !== 1'b0 || rbr_data !== 8'd0) begin
      errors++;
      $display("FAIL basic_empty: got count=%0d dr=%b data=%h want 0 0 00",
               rx_count, data_ready, rbr_data);
    end
  endtask

  task automatic test_empty_read();
    read();
    checks++;
    if (rx_count !== 5'd0 || rbr_data !== 8'd0) begin
      errors++;
      $display("FAIL empty_read: got count=%0d data=%h want 0 00", rx_count, rbr_data);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i <= 16; i++) load(i[7:0], 0, 0, 0, 0);
    checks++;
    if (rx_count !== 5'd16 || overrun_error !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got count=%0d ovr=%b want 16 1", rx_count, overrun_error);
    end
    // Overrun coinciding with an LSR read must stay set.
    lsr_rd = 1'b1;
    load(8'hEE, 0, 0, 0, 0);
    lsr_rd = 1'b0;
    checks++;
    if (overrun_error !== 1'b1) begin
      errors++;
      $display("FAIL overrun_vs_lsr: got %b want 1", overrun_error);
    end
    lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
    checks++;
    if (overrun_error !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b want 0", overrun_error);
    end
  endtask

  task automatic test_full_rdwr();
    load(8'h55, 0, 0, 0, 1);
    checks++;
    if (rx_count !== 5'd16 || overrun_error !== 1'b0 || rbr_data !== 8'h01) begin
      errors++;
      $display("FAIL full_rdwr: got count=%0d ovr=%b head=%h want 16 0 01",
               rx_count, overrun_error, rbr_data);
    end
    while (sb.size() != 0) begin
      checks++;
      if (rbr_data !== sb[0][7:0]) begin
        errors++;
        $display("FAIL full_drain: got %h want %h", rbr_data, sb[0][7:0]);
      end
      if (sb.size() == 1) begin
        checks++;
        if (rbr_data !== 8'h55) begin
          errors++;
          $display("FAIL full_last: got %h want 55", rbr_data);
        end
      end
      read();
    end
  endtask

  task automatic test_errors();
    load(8'h12, 0, 1, 0, 0);
    load(8'h34, 0, 0, 0, 0);
    checks++;
    if (lsr_fe !== 1'b1 || rx_fifo_error !== 1'b1 || rbr_data !== 8'h12) begin
      errors++;
      $display("FAIL err_head: got fe=%b fifo_err=%b data=%h want 1 1 12",
               lsr_fe, rx_fifo_error, rbr_data);
    end
    read();
    checks++;
    if (lsr_fe !== 1'b0 || rx_fifo_error !== 1'b0 || rbr_data !== 8'h34) begin
      errors++;
      $display("FAIL err_pop: got fe=%b fifo_err=%b data=%h want 0 0 34",
               lsr_fe, rx_fifo_error, rbr_data);
    end
    read();
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_head;
    int nerr;
    int op;
    for (int c = 0; c < 120; c++) begin
      exp_head = (sb.size() != 0) ? sb[0] : 11'd0;
      nerr = 0;
      foreach (sb[k]) if (sb[k][10:8] != 3'd0) nerr++;
      checks++;
      if ({lsr_bi, lsr_fe, lsr_pe, rbr_data} !== exp_head ||
          rx_count !== sb.size() || data_ready !== (sb.size() != 0) ||
          rx_fifo_error !== (nerr != 0)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got head=%h count=%0d fifo_err=%b want %h %0d %b",
                 c, {lsr_bi, lsr_fe, lsr_pe, rbr_data}, rx_count, rx_fifo_error,
                 exp_head, sb.size(), (nerr != 0));
      end
      op = $urandom_range(0, 9);
      if (c >= 80 && op < 6) op = 6;
      if (op < 5) begin
        load($urandom_range(0, 255), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), 1'b0);
      end else if (op < 7) begin
        read();
      end else if (op < 9) begin
        load($urandom_range(0, 255), ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 1'b1);
      end else begin
        cyc();
      end
    end
    while (sb.size() != 0) read();
    lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
  endtask

  task automatic test_trigger();
    rx_trig = 2'b01;
    for (int i = 0; i < 3; i++) load(8'h60 + i[7:0], 0, 0, 0, 0);
    checks++;
    if (rx_trig_int !== 1'b0) begin
      errors++;
      $display("FAIL trig_below: got %b want 0", rx_trig_int);
    end
    load(8'h63, 0, 0, 0, 0);
    checks++;
    if (rx_trig_int !== 1'b1) begin
      errors++;
      $display("FAIL trig_reached: got %b want 1", rx_trig_int);
    end
    set_fifo_en(1'b0);
    checks++;
    if (rx_count !== 5'd0 || rx_trig_int !== 1'b0) begin
      errors++;
      $display("FAIL trig_flush: got count=%0d trig=%b want 0 0", rx_count, rx_trig_int);
    end
  endtask

  task automatic test_holding();
    load(8'hA1, 0, 0, 0, 0);
    load(8'hB2, 0, 0, 0, 0);
    checks++;
    if (rx_count !== 5'd1 || overrun_error !== 1'b1 || rbr_data !== 8'hA1 ||
        rx_trig_int !== 1'b1) begin
      errors++;
      $display("FAIL hold_overrun: got count=%0d ovr=%b data=%h trig=%b want 1 1 a1 1",
               rx_count, overrun_error, rbr_data, rx_trig_int);
    end
    load(8'hC3, 0, 0, 0, 1);
    checks++;
    if (rx_count !== 5'd1 || rbr_data !== sb[0][7:0]) begin
      errors++;
      $display("FAIL hold_rdwr: got count=%0d data=%h want 1 %h",
               rx_count, rbr_data, sb[0][7:0]);
    end
  endtask

  task automatic test_utrrst();
    utrrst = 1'b1;
    load(8'hD4, 0, 0, 0, 0);
    utrrst = 1'b0;
    sb.delete();
    checks++;
    if (rx_count !== 5'd0 || overrun_error !== 1'b0 || rbr_data !== 8'd0) begin
      errors++;
      $display("FAIL utrrst_flush: got count=%0d ovr=%b data=%h want 0 0 00",
               rx_count, overrun_error, rbr_data);
    end
  endtask

  task automatic test_timeout();
    logic exp_to;
`ifdef UART_RX_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    set_fifo_en(1'b1);
    load(8'h77, 0, 0, 0, 0);
    for (int t = 0; t < 3; t++) begin
      char_tick = 1'b1; cyc(); char_tick = 1'b0; cyc();
    end
    checks++;
    if (rx_timeout_int !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b want 0", rx_timeout_int);
    end
    char_tick = 1'b1; cyc(); char_tick = 1'b0; cyc();
    checks++;
    if (rx_timeout_int !== exp_to) begin
      errors++;
      $display("FAIL timeout_fire: got %b want %b", rx_timeout_int, exp_to);
    end
    read();
    checks++;
    if (rx_timeout_int !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b want 0", rx_timeout_int);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_read();
    test_overrun();
    test_full_rdwr();
    test_errors();
    test_back_to_back();
    test_trigger();
    test_holding();
    test_utrrst();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
